// File: rtl/truth_table_pkg.sv
// Shared constants, sweep FSM state encoding and index-width helper for the truth-table sweeper.
// Combinational definitions only; no timing or flow control lives here.
package truth_table_pkg;

   localparam int DEF_NUM_IN = 4;
   localparam int DEF_NUM_FN = 10;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Index width that stays at least one bit even for a single entry.
   function automatic int idx_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/tt_store.sv
// Truth-table register file: one write port, one read port returning every function at a minterm.
// Write visible next cycle; read is combinational; no backpressure, out-of-range writes are dropped.
module tt_store
   import truth_table_pkg::*;
#(
   parameter int NUM_IN = DEF_NUM_IN,
   parameter int NUM_FN = DEF_NUM_FN,
   parameter int FN_W   = idx_w(DEF_NUM_FN)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [FN_W-1:0]       wr_fn,
   input  logic [2**NUM_IN-1:0]  wr_table,
   input  logic [NUM_IN-1:0]     rd_idx,
   output logic [NUM_FN-1:0]     rd_bits
);

   logic [NUM_FN-1:0][2**NUM_IN-1:0] tables;

   // Only indices that match a real channel write; anything else falls through untouched.
   always_ff @(posedge clk) begin
      if (rst) begin
         tables <= '0;
      end else begin
         for (int k = 0; k < NUM_FN; k++) begin
            if (wr_en && wr_fn == FN_W'(k)) begin
               tables[k] <= wr_table;
            end
         end
      end
   end

   always_comb begin
      rd_bits = '0;
      for (int k = 0; k < NUM_FN; k++) begin
         rd_bits[k] = tables[k][rd_idx];
      end
   end

endmodule

// File: rtl/truth_table_sweeper.sv
// Sweeps every minterm of NUM_FN stored truth tables, one row per accepted valid/ready beat.
// First row one cycle after start; rows hold while row_ready is low; cfg writes only taken in IDLE.
module truth_table_sweeper
   import truth_table_pkg::*;
#(
   parameter int NUM_IN = DEF_NUM_IN,
   parameter int NUM_FN = DEF_NUM_FN
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       cfg_valid,
   output logic                       cfg_ready,
   input  logic [idx_w(NUM_FN)-1:0]   cfg_fn,
   input  logic [2**NUM_IN-1:0]       cfg_table,
   input  logic                       start,
   output logic                       busy,
   output logic                       row_valid,
   input  logic                       row_ready,
   output logic [NUM_IN-1:0]          row_idx,
   output logic [NUM_FN-1:0]          row_out,
   output logic                       done
);

   localparam int FN_W = idx_w(NUM_FN);
   localparam logic [NUM_IN-1:0] LAST_ROW = '1;

   state_t              state, state_nxt;
   logic [NUM_IN-1:0]   cnt, cnt_nxt;
   logic [NUM_FN-1:0]   rd_bits;
   logic                wr_en;

   assign wr_en = cfg_valid && (state == IDLE);

   tt_store #(
      .NUM_IN (NUM_IN),
      .NUM_FN (NUM_FN),
      .FN_W   (FN_W)
   ) u_store (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en),
      .wr_fn    (cfg_fn),
      .wr_table (cfg_table),
      .rd_idx   (cnt),
      .rd_bits  (rd_bits)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      cfg_ready = 1'b0;
      busy      = 1'b0;
      row_valid = 1'b0;
      row_idx   = '0;
      row_out   = '0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            cfg_ready = 1'b1;
            if (start) begin
               state_nxt = SWEEP;
               cnt_nxt   = '0;
            end
         end
         SWEEP: begin
            busy      = 1'b1;
            row_valid = 1'b1;
            row_idx   = cnt;
            row_out   = rd_bits;
            // The last row exits to DONE instead of wrapping the counter.
            if (row_ready) begin
               if (cnt == LAST_ROW) begin
                  state_nxt = DONE;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt + NUM_IN'(1);
               end
            end
         end
         DONE: begin
            busy      = 1'b1;
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper with NUM_IN=4, NUM_FN=10.
// Table-driven row expectations plus hand sequences for stalls, ignored requests and mid-sweep reset.
module tb_truth_table_sweeper;

   logic        clk = 1'b0;
   logic        rst;
   logic        cfg_valid;
   logic        cfg_ready;
   logic [3:0]  cfg_fn;
   logic [15:0] cfg_table;
   logic        start;
   logic        busy;
   logic        row_valid;
   logic        row_ready;
   logic [3:0]  row_idx;
   logic [9:0]  row_out;
   logic        done;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [3:0] idx;
      logic [1:0] f9_f0;
   } vec_t;

   vec_t       vecs[16];
   logic [9:0] exp_rows[16];

   always #5 clk = ~clk;

   truth_table_sweeper #(.NUM_IN(4), .NUM_FN(10)) dut (
      .clk       (clk),
      .rst       (rst),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_fn    (cfg_fn),
      .cfg_table (cfg_table),
      .start     (start),
      .busy      (busy),
      .row_valid (row_valid),
      .row_ready (row_ready),
      .row_idx   (row_idx),
      .row_out   (row_out),
      .done      (done)
   );

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cfg_write(input logic [3:0] fn, input logic [15:0] tab);
      cfg_valid = 1'b1;
      cfg_fn    = fn;
      cfg_table = tab;
      chk("cfg_ready on write", 32'(cfg_ready), 32'd1);
      step;
      cfg_valid = 1'b0;
   endtask

   // Runs one sweep against exp_rows; optional stall, in-sweep request injection and start-cycle write.
   task automatic sweep(input string tag, input int stall_row, input int stall_len,
                        input int inject_row, input bit with_cfg,
                        input logic [3:0] cw_fn, input logic [15:0] cw_tab);
      int r;
      int cyc;
      int stalls;
      bit injected;
      r = 0; cyc = 0; stalls = 0; injected = 1'b0;
      start = 1'b1;
      if (with_cfg) begin
         cfg_valid = 1'b1;
         cfg_fn    = cw_fn;
         cfg_table = cw_tab;
      end
      chk({tag, " idle cfg_ready"}, 32'(cfg_ready), 32'd1);
      step;
      start = 1'b0;
      cfg_valid = 1'b0;
      while (done !== 1'b1 && cyc < 60) begin
         chk({tag, " row_valid"}, 32'(row_valid), 32'd1);
         chk({tag, " busy"}, 32'(busy), 32'd1);
         if (r < 16) begin
            chk({tag, " row_idx"}, 32'(row_idx), 32'(r));
            chk({tag, " row_out"}, 32'(row_out), 32'(exp_rows[r]));
         end else begin
            chk({tag, " row overrun"}, 32'(r), 32'd15);
         end
         row_ready = 1'b1;
         cfg_valid = 1'b0;
         start     = 1'b0;
         if (r == stall_row && stalls < stall_len) begin
            row_ready = 1'b0;
            stalls++;
         end
         if (r == inject_row && !injected) begin
            cfg_valid = 1'b1;
            cfg_fn    = 4'd0;
            cfg_table = 16'hFFFF;
            start     = 1'b1;
            injected  = 1'b1;
            chk({tag, " cfg_ready in sweep"}, 32'(cfg_ready), 32'd0);
         end
         if (row_ready) r++;
         step;
         cyc++;
      end
      cfg_valid = 1'b0;
      start     = 1'b0;
      row_ready = 1'b1;
      chk({tag, " done pulse"}, 32'(done), 32'd1);
      chk({tag, " cycles to done"}, 32'(cyc), 32'(16 + stall_len));
      chk({tag, " row_valid in done"}, 32'(row_valid), 32'd0);
      chk({tag, " row_idx in done"}, 32'(row_idx), 32'd0);
      chk({tag, " row_out in done"}, 32'(row_out), 32'd0);
      step;
      chk({tag, " done after"}, 32'(done), 32'd0);
      chk({tag, " busy after"}, 32'(busy), 32'd0);
      chk({tag, " cfg_ready after"}, 32'(cfg_ready), 32'd1);
   endtask

   initial begin
      // {fn9, fn0} per minterm for fn0=0x6F62, fn9=0xB6A4.
      vecs[0]  = '{4'd0,  2'b00}; vecs[1]  = '{4'd1,  2'b01};
      vecs[2]  = '{4'd2,  2'b10}; vecs[3]  = '{4'd3,  2'b00};
      vecs[4]  = '{4'd4,  2'b00}; vecs[5]  = '{4'd5,  2'b11};
      vecs[6]  = '{4'd6,  2'b01}; vecs[7]  = '{4'd7,  2'b10};
      vecs[8]  = '{4'd8,  2'b01}; vecs[9]  = '{4'd9,  2'b11};
      vecs[10] = '{4'd10, 2'b11}; vecs[11] = '{4'd11, 2'b01};
      vecs[12] = '{4'd12, 2'b10}; vecs[13] = '{4'd13, 2'b11};
      vecs[14] = '{4'd14, 2'b01}; vecs[15] = '{4'd15, 2'b10};

      rst = 1'b1; cfg_valid = 1'b0; cfg_fn = 4'd0; cfg_table = 16'h0;
      start = 1'b0; row_ready = 1'b1;
      step; step;
      rst = 1'b0;
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset cfg_ready", 32'(cfg_ready), 32'd1);
      chk("reset row_valid", 32'(row_valid), 32'd0);
      chk("reset done", 32'(done), 32'd0);
      chk("reset row_idx", 32'(row_idx), 32'd0);
      chk("reset row_out", 32'(row_out), 32'd0);

      for (int i = 0; i < 16; i++) exp_rows[i] = 10'h000;
      sweep("zero sweep", -1, 0, -1, 1'b0, 4'd0, 16'h0);

      cfg_write(4'd0, 16'h6F62);
      cfg_write(4'd9, 16'hB6A4);
      for (int i = 0; i < 16; i++)
         exp_rows[vecs[i].idx] = {vecs[i].f9_f0[1], 8'h00, vecs[i].f9_f0[0]};
      sweep("table sweep", -1, 0, -1, 1'b0, 4'd0, 16'h0);
      sweep("stall sweep", 4, 3, -1, 1'b0, 4'd0, 16'h0);
      sweep("inject sweep", -1, 0, 3, 1'b0, 4'd0, 16'h0);
      sweep("post inject sweep", -1, 0, -1, 1'b0, 4'd0, 16'h0);

      // Reset in the middle of a sweep.
      start = 1'b1;
      step;
      start = 1'b0;
      row_ready = 1'b1;
      for (int i = 0; i < 7; i++) step;
      chk("mid rst at row", 32'(row_idx), 32'd7);
      rst = 1'b1;
      step;
      rst = 1'b0;
      chk("mid rst row_valid", 32'(row_valid), 32'd0);
      chk("mid rst busy", 32'(busy), 32'd0);
      chk("mid rst cfg_ready", 32'(cfg_ready), 32'd1);
      chk("mid rst done", 32'(done), 32'd0);
      step;
      chk("mid rst no done", 32'(done), 32'd0);
      for (int i = 0; i < 16; i++) exp_rows[i] = 10'h000;
      sweep("after rst sweep", -1, 0, -1, 1'b0, 4'd0, 16'h0);

      // Write and start together; then an out-of-range write that must be dropped.
      for (int i = 0; i < 16; i++) exp_rows[i] = 10'h008;
      sweep("cfg+start sweep", -1, 0, -1, 1'b1, 4'd3, 16'hFFFF);
      cfg_write(4'd12, 16'hFFFF);
      sweep("bad fn sweep", -1, 0, -1, 1'b0, 4'd0, 16'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/truth_table_sweeper.md
TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

Interface
REQ-001 SHALL have parameter NUM_IN, default 4: number of function inputs; legal range 1..8.
REQ-002 SHALL have parameter NUM_FN, default 10: number of independent functions (channels); legal range 1..32.
REQ-003 SHALL have one clock domain; reset is synchronous and active-high.
REQ-004 SHALL provide ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- cfg_valid  in  1  table-write request
- cfg_ready  out  1  table-write accepted this cycle when high with cfg_valid
- cfg_fn  in  clog2(NUM_FN) (min 1)  function index to write
- cfg_table  in  2**NUM_IN  truth table; bit m = output for minterm m
- start  in  1  begin sweep pulse
- busy  out  1  high in SWEEP and DONE
- row_valid  out  1  row_idx/row_out valid
- row_ready  in  1  consumer accepts row
- row_idx  out  NUM_IN  current minterm index; MSB = first input (w)
- row_out  out  NUM_FN  bit k = function k evaluated at row_idx
- done  out  1  one-cycle sweep-complete pulse

Function
REQ-005 SHALL hold NUM_FN truth-table registers of 2**NUM_IN bits each; all zero after reset.
REQ-006 SHALL use FSM states IDLE, SWEEP, DONE.
REQ-007 cfg_ready SHALL equal (state==IDLE); a write occurs on cfg_valid&&cfg_ready and becomes visible the next cycle.
REQ-008 A write with cfg_fn >= NUM_FN SHALL be accepted and discarded, with no table change.
REQ-009 start in IDLE SHALL transition to SWEEP with row counter 0; start outside IDLE SHALL be ignored.
REQ-010 start and an accepted cfg write in the same IDLE cycle SHALL both take effect; the sweep SHALL use the newly written table.
REQ-011 In SWEEP, row_valid SHALL be 1, row_idx SHALL equal the counter, and row_out[k] SHALL equal table[k][row_idx], with no added latency beyond the counter register.
REQ-012 The first row SHALL be valid in the cycle after start is accepted.
REQ-013 The counter SHALL advance by 1 on each row_valid&&row_ready.
REQ-014 While row_valid && !row_ready, row_idx and row_out SHALL be held stable.
REQ-015 Acceptance of row 2**NUM_IN-1 SHALL move to DONE with no wrap-around; DONE SHALL last exactly one cycle with done=1 and row_valid=0, then return to IDLE.
REQ-016 Outside SWEEP, row_valid SHALL be 0 and row_idx/row_out SHALL be 0; done SHALL be 0 outside DONE.

Reset
REQ-017 rst SHALL force IDLE, zero all tables and the counter, and set row_valid=0, done=0, busy=0, cfg_ready=1 in the following cycle.
REQ-018 rst mid-sweep SHALL abort with no done pulse and SHALL take priority over cfg_valid and start.

Structure
REQ-019 Package truth_table_pkg SHALL hold the default NUM_IN/NUM_FN values, the FSM state enum (IDLE/SWEEP/DONE), and the index-width helper.
REQ-020 Table storage SHALL be sub-module tt_store: one write port, with a read port returning all NUM_FN bits at one minterm index.
REQ-021 Target size: 120-400 lines of RTL total.

Verification (NUM_IN=4, NUM_FN=10)
REQ-022 Reset, then start with row_ready=1 SHALL produce row_idx 0..15 on 16 consecutive cycles with row_out=0, then done=1 for one cycle, then busy=0.
REQ-023 Load fn0=0x6F62 and fn9=0xB6A4, then sweep: rows 0, 1, 2 and 13 SHALL have {row_out[9],row_out[0]} equal to 00, 01, 10 and 11 respectively.
REQ-024 Holding row_ready=0 for 3 cycles at row 4 SHALL keep row_idx=4 and row_out stable with row_valid=1; the whole sweep SHALL take 19 cycles from first row to done.
REQ-025 cfg_valid or start during SWEEP SHALL see cfg_ready=0 and have no effect: a following sweep reproduces the old tables, and there is no restart.
REQ-026 rst asserted at row 7 SHALL give row_valid=0, busy=0, cfg_ready=1 in the next cycle, and a following sweep SHALL output all-zero rows.
REQ-027 start with cfg_fn=3/0xFFFF in the same IDLE cycle SHALL give row_out[3]=1 from row 0; a write with cfg_fn=12 SHALL leave every table unchanged.
